// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default datapath width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell of the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through one full adder.
//
// Handshake: start is sampled only while idle; the edge that sees it captures
// a/b/cin and raises busy for exactly WIDTH cycles. done then pulses for one
// cycle with sum/cout/ovf valid; those results hold until the next completion.
// start while busy or done is ignored, and the earliest next acceptance is two
// edges after the final RUN edge.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_MSB  = CW'(WIDTH - 2);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             cmsb;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Control FSM and serial datapath: capture on start, shift one bit per RUN edge, publish on last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        cmsb  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CNT_MSB) begin
                        cmsb <= fa_co;
                    end
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, acc[WIDTH-1:1]};
                        cout  <= fa_co;
                        ovf   <= fa_co ^ cmsb;
                        // Park the counter rather than letting it wrap.
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decoded purely from registered state.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_serial_adder;
    import arith_pkg::*;

    localparam int W8  = 8;
    localparam int W32 = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic           start8, cin8, busy8, done8, cout8, ovf8;
    logic [W8-1:0]  a8, b8, sum8;
    state_t         st8;
    logic           start32, cin32, busy32, done32, cout32, ovf32;
    logic [W32-1:0] a32, b32, sum32;
    state_t         st32;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
        .dbg_state(st8)
    );

    serial_adder #(.WIDTH(W32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32),
        .dbg_state(st32)
    );

    // ---------------- reference model ----------------
    // Result packed as {ovf, cout, sum}, computed with plain integer addition.
    function automatic logic [W8+1:0] ref8(input logic [W8-1:0] x, input logic [W8-1:0] y,
                                           input logic c);
        logic [W8:0] t;
        logic        v;
        t = {1'b0, x} + {1'b0, y} + {{W8{1'b0}}, c};
        v = (x[W8-1] == y[W8-1]) && (t[W8-1] != x[W8-1]);
        return {v, t};
    endfunction

    function automatic logic [W32+1:0] ref32(input logic [W32-1:0] x, input logic [W32-1:0] y,
                                             input logic c);
        logic [W32:0] t;
        logic         v;
        t = {1'b0, x} + {1'b0, y} + {{W32{1'b0}}, c};
        v = (x[W32-1] == y[W32-1]) && (t[W32-1] != x[W32-1]);
        return {v, t};
    endfunction

    // Timing model: an accepted request keeps the adder busy for WIDTH cycles,
    // then done is shown for one cycle, then the adder is idle again.
    logic [W8+1:0]  exp_q8[$];
    logic [W32+1:0] exp_q32[$];
    int             run8, run32;
    logic           mdone8, mdone32;
    logic [W8+1:0]  held8;
    logic [W32+1:0] held32;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run8   <= 0;
            mdone8 <= 1'b0;
            exp_q8.delete();
        end else if (mdone8) begin
            mdone8 <= 1'b0;
        end else if (run8 != 0) begin
            run8 <= run8 - 1;
            if (run8 == 1) mdone8 <= 1'b1;
        end else if (start8) begin
            exp_q8.push_back(ref8(a8, b8, cin8));
            run8 <= W8;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run32   <= 0;
            mdone32 <= 1'b0;
            exp_q32.delete();
        end else if (mdone32) begin
            mdone32 <= 1'b0;
        end else if (run32 != 0) begin
            run32 <= run32 - 1;
            if (run32 == 1) mdone32 <= 1'b1;
        end else if (start32) begin
            exp_q32.push_back(ref32(a32, b32, cin32));
            run32 <= W32;
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance to the falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            held8  = '0;
            held32 = '0;
        end
        if (mdone8) begin
            checks++;
            if (exp_q8.size() == 0) begin
                errors++;
                $display("FAIL q8_empty: got empty queue expected an entry at %0t", $time);
            end else begin
                held8 = exp_q8.pop_front();
            end
        end
        if (mdone32) begin
            checks++;
            if (exp_q32.size() == 0) begin
                errors++;
                $display("FAIL q32_empty: got empty queue expected an entry at %0t", $time);
            end else begin
                held32 = exp_q32.pop_front();
            end
        end
        check1("busy8",  64'(busy8),  64'(run8 != 0));
        check1("done8",  64'(done8),  64'(mdone8));
        check1("res8",   64'({ovf8, cout8, sum8}), 64'(held8));
        check1("busy32", 64'(busy32), 64'(run32 != 0));
        check1("done32", 64'(done32), 64'(mdone32));
        check1("res32",  64'({ovf32, cout32, sum32}), 64'(held32));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_done8(input string name);
        int n;
        n = 0;
        while (!done8 && n < W8 + 6) begin
            tick();
            n++;
        end
        checks++;
        if (!done8) begin
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, W8 + 6);
        end
    endtask

    // Single operation with a hand-computed expected {ovf, cout, sum}.
    task automatic op8(input string name, input logic [W8-1:0] x, input logic [W8-1:0] y,
                       input logic c, input logic [W8+1:0] lit);
        start8 = 1'b1;
        a8     = x;
        b8     = y;
        cin8   = c;
        tick();
        start8 = 1'b0;
        wait_done8(name);
        check1({name, "_dut"},   64'({ovf8, cout8, sum8}), 64'(lit));
        check1({name, "_model"}, 64'(held8), 64'(lit));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        held8   = '0;
        held32  = '0;

        #1;
        check1("rst_busy8", 64'(busy8), 64'd0);
        check1("rst_done8", 64'(done8), 64'd0);
        check1("rst_res8",  64'({ovf8, cout8, sum8}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors: {ovf, cout, sum}.
        op8("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 10'h04B);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 10'h100);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 10'h280);
        op8("add_80_80", 8'h80, 8'h80, 1'b0, 10'h300);
        op8("add_00_c1", 8'h00, 8'h00, 1'b1, 10'h001);
        op8("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 10'h1FF);

        // Start and operand changes mid-run must be ignored.
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8("midrun");
        check1("midrun_dut", 64'({ovf8, cout8, sum8}), 64'h033);
        tick();
        tick();
        check1("midrun_single_done", 64'(done8), 64'd0);

        // Asynchronous reset between edges aborts a run.
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check1("arst_busy8", 64'(busy8), 64'd0);
        check1("arst_done8", 64'(done8), 64'd0);
        check1("arst_res8",  64'({ovf8, cout8, sum8}), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W8 + 4; i++) tick();
        op8("after_rst", 8'h01, 8'h01, 1'b0, 10'h002);

        // Back-to-back with start held high and operands changing every cycle.
        start8 = 1'b1;
        for (int i = 0; i < 1000 * (W8 + 2); i++) begin
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            tick();
        end
        start8 = 1'b0;
        for (int i = 0; i < W8 + 4; i++) tick();

        // WIDTH=32: one literal, then back-to-back random traffic.
        start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0;
        tick();
        start32 = 1'b0;
        for (int i = 0; i < W32 + 2; i++) tick();
        check1("w32_wrap_dut", 64'({ovf32, cout32, sum32}), 64'h1_0000_0000);
        check1("w32_wrap_model", 64'(held32), 64'h1_0000_0000);

        start32 = 1'b1;
        for (int i = 0; i < 100 * (W32 + 2); i++) begin
            a32   = $urandom();
            b32   = $urandom();
            cin32 = 1'($urandom_range(0, 1));
            tick();
        end
        start32 = 1'b0;
        for (int i = 0; i < W32 + 4; i++) tick();

        check1("q8_drained",  64'(exp_q8.size()),  64'd0);
        check1("q32_drained", 64'(exp_q32.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
